// File: rtl/se15_pkg.sv
// Shared constants and types for the se15 scrambler/descrambler pair.
// Config addresses, reset defaults and the word/byte types used on both ends.
package se15_pkg;
    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    localparam logic [11:0] A_POLY = 12'h000;
    localparam logic [11:0] A_SEED = 12'h004;
    localparam logic [11:0] A_MASK = 12'h008;

    localparam word_t DEF_POLY = 32'h80200003;
    localparam word_t DEF_SEED = 32'hFFFFFFFF;
    localparam word_t DEF_MASK = 32'h000000FF;
endpackage

// File: rtl/se15_lfsr_step8.sv
// Advances a Galois LFSR eight steps and returns the eight output bits as a keystream byte.
// Purely combinational (zero latency), no flow control.
module se15_lfsr_step8
    import se15_pkg::*;
(
    input  word_t state,
    input  word_t poly,
    output word_t next_state,
    output byte_t ks
);
    word_t s;

    always_comb begin
        s  = state;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            ks[i] = s[0];
            s     = s >> 1;
            if (ks[i]) s = s ^ poly;
        end
        next_state = s;
    end
endmodule

// File: rtl/se15_descrambler.sv
// Recovers the data byte from each se15 scrambled word: 3-cycle latency, one word per clock,
// no backpressure (every pushin yields exactly one pushout three edges later).
module se15_descrambler
    import se15_pkg::*;
#(
    parameter int    WIN      = 32,
    parameter int    WOUT     = 8,
    parameter int    AW       = 12,
    parameter word_t RST_POLY = DEF_POLY,
    parameter word_t RST_SEED = DEF_SEED,
    parameter word_t RST_MASK = DEF_MASK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     lfsrdin,
    input  logic            pushin,
    input  logic [WIN-1:0]  datain,
    output logic            pushout,
    output logic [WOUT-1:0] dataout
);
    word_t poly_q, lfsr_q, mask_q;
    word_t lfsr_nxt;
    byte_t ks;

    logic  s1_vld;
    word_t s1_word, s1_mask;
    byte_t s1_ks;

    logic  s2_vld;
    byte_t s2_ext, s2_ks;

    byte_t      ext;
    logic [3:0] sel_cnt;

    logic wr_poly, wr_seed, wr_mask;
    assign wr_poly = write && (addr == AW'(A_POLY));
    assign wr_seed = write && (addr == AW'(A_SEED));
    assign wr_mask = write && (addr == AW'(A_MASK));

    se15_lfsr_step8 u_step (
        .state      (lfsr_q),
        .poly       (poly_q),
        .next_state (lfsr_nxt),
        .ks         (ks)
    );

    // Walk the staged mask from the LSB; the k-th set bit feeds ext[k], stopping after eight.
    always_comb begin
        ext     = '0;
        sel_cnt = '0;
        for (int i = 0; i < WIN; i++) begin
            if (s1_mask[i] && (sel_cnt < 4'd8)) begin
                ext[sel_cnt[2:0]] = s1_word[i];
                sel_cnt           = sel_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            poly_q  <= RST_POLY;
            lfsr_q  <= RST_SEED;
            mask_q  <= RST_MASK;
            s1_vld  <= 1'b0;
            s1_word <= '0;
            s1_mask <= '0;
            s1_ks   <= '0;
            s2_vld  <= 1'b0;
            s2_ext  <= '0;
            s2_ks   <= '0;
            pushout <= 1'b0;
            dataout <= '0;
        end else begin
            if (wr_poly) poly_q <= lfsrdin;
            if (wr_mask) mask_q <= lfsrdin;
            // A seed write overrides the advance; a word pushed alongside it already used the old state.
            if (wr_seed)     lfsr_q <= lfsrdin;
            else if (pushin) lfsr_q <= lfsr_nxt;

            s1_vld <= pushin;
            if (pushin) begin
                s1_word <= datain;
                s1_mask <= mask_q;
                s1_ks   <= ks;
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_ext <= ext;
                s2_ks  <= s1_ks;
            end

            pushout <= s2_vld;
            if (s2_vld) dataout <= s2_ext ^ s2_ks;
        end
    end
endmodule

// File: tb/tb_se15_descrambler.sv
// Directed-vector bench for se15_descrambler; expected bytes are hand-computed and
// tracked through a 3-deep expectation pipe checked on every falling edge.
module tb_se15_descrambler;
    import se15_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [11:0] addr;
    logic [31:0] lfsrdin;
    logic        pushin;
    logic [31:0] datain;
    logic        pushout;
    logic [7:0]  dataout;

    int    checks = 0;
    int    passes = 0;
    int    fails  = 0;
    string step   = "init";
    logic  ev [3];
    byte_t eb [3];
    byte_t lastb;

    se15_descrambler dut (
        .clk     (clk),
        .rst     (rst),
        .write   (write),
        .addr    (addr),
        .lfsrdin (lfsrdin),
        .pushin  (pushin),
        .datain  (datain),
        .pushout (pushout),
        .dataout (dataout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0;
            eb[i] = 8'h00;
        end
        lastb = 8'h00;
    endtask

    // Drive one cycle of inputs at a falling edge, then check outputs at the next falling edge.
    task automatic cyc(input logic p, input logic [31:0] w, input logic wr,
                       input logic [11:0] a, input logic [31:0] d, input byte_t e);
        pushin  = p;
        datain  = w;
        write   = wr;
        addr    = a;
        lfsrdin = d;
        ev[2] = ev[1]; eb[2] = eb[1];
        ev[1] = ev[0]; eb[1] = eb[0];
        ev[0] = p;     eb[0] = e;
        @(negedge clk);
        if (ev[2]) lastb = eb[2];
        chk("pushout", {31'b0, pushout}, {31'b0, ev[2]});
        chk("dataout", {24'b0, dataout}, {24'b0, lastb});
    endtask

    task automatic wr_cfg(input logic [11:0] a, input logic [31:0] d);
        cyc(1'b0, 32'h0, 1'b1, a, d, 8'h00);
    endtask

    task automatic push(input logic [31:0] w, input byte_t e);
        cyc(1'b1, w, 1'b0, 12'h000, 32'h0, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 12'h000, 32'h0, 8'h00);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        pushin = 1'b0;
        write  = 1'b0;
        clear_pipe();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pushout", {31'b0, pushout}, 32'h0);
        chk("rst_dataout", {24'b0, dataout}, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; write = 1'b0; addr = '0; lfsrdin = '0; pushin = 1'b0; datain = '0;
        clear_pipe();
        step = "reset";
        do_reset();

        // Default config: POLY=80200003, SEED=FFFFFFFF gives keystream 49, 92; data in the low byte.
        step = "vec_default";
        push(32'hABCDE113, 8'h5A);
        push(32'h123456AE, 8'h3C);
        idle(3);

        step = "case1";
        wr_cfg(A_POLY, 32'h0);
        wr_cfg(A_MASK, 32'h0000_00FF);
        wr_cfg(A_SEED, 32'h0000_3CA5);
        push(32'h12345600, 8'hA5);
        push(32'h000000FF, 8'hC3);
        idle(3);

        // MASK is rewritten alongside each push; each word must use the mask staged with it.
        step = "case2_mask";
        wr_cfg(A_SEED, 32'h0);
        wr_cfg(A_MASK, 32'hF000_000F);
        cyc(1'b1, 32'hA000_000B, 1'b1, A_MASK, 32'h0000_000F, 8'hAB);
        cyc(1'b1, 32'h0000_0005, 1'b1, A_MASK, 32'hFFFF_0000, 8'h05);
        push(32'h1234_0000, 8'h34);
        idle(3);

        // Scrambled stream with data in bits 15:8, entropy elsewhere; keystream EF, CD, AB, 89.
        step = "vec_stream";
        wr_cfg(A_MASK, 32'h0000_FF00);
        wr_cfg(A_SEED, 32'h89AB_CDEF);
        push(32'hCAFE_FE77, 8'h11);
        push(32'h1234_EF56, 8'h22);
        push(32'hFFFF_9800, 8'h33);
        push(32'h0000_CDFF, 8'h44);
        push(32'h5555_7700, 8'h77);
        idle(3);

        step = "case4_same_cycle";
        wr_cfg(A_MASK, 32'h0000_00FF);
        wr_cfg(A_SEED, 32'h0000_A5FF);
        cyc(1'b1, 32'h0, 1'b1, A_SEED, 32'h0000_00FF, 8'hFF);
        push(32'h0, 8'hFF);
        idle(3);

        step = "case5_reset_midflight";
        push(32'h0000_0000, 8'h00);
        rst    = 1'b0;
        pushin = 1'b0;
        clear_pipe();
        @(negedge clk);
        chk("mid_pushout", {31'b0, pushout}, 32'h0);
        chk("mid_dataout", {24'b0, dataout}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        push(32'h0, 8'h49);
        push(32'h0, 8'h92);
        idle(3);

        step = "case6_bad_addr";
        wr_cfg(A_POLY, 32'h0);
        wr_cfg(A_MASK, 32'h0000_00FF);
        wr_cfg(A_SEED, 32'h0000_3CA5);
        wr_cfg(12'h00C, 32'hDEAD_BEEF);
        wr_cfg(12'h001, 32'h1357_9BDF);
        push(32'h12345600, 8'hA5);
        push(32'h000000FF, 8'hC3);
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
